// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD up/down timer with prescaled stepping, wrap/stop terminal
// handling and active-low 7-segment decode for every digit.
module bcd_countdown_timer #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 15_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  up,
  input  logic                  wrap_en,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] NINES     = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;

  logic [CW-1:0] terminal;
  logic          at_term;
  logic [CW-1:0] stepped;
  logic [CW-1:0] preset_clamped;

  // Ripple-carry BCD increment; all nines rolls over to all zeros.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    logic          carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  // Ripple-borrow BCD decrement; all zeros rolls under to all nines.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    logic          borrow;
    result = value;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (value[4*i +: 4] == 4'd0) begin
          result[4*i +: 4] = 4'd9;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    return result;
  endfunction

  // Non-decimal preset digits saturate to 9 so count always stays valid BCD.
  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    result = value;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) begin
        result[4*i +: 4] = 4'd9;
      end
    end
    return result;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; unreachable codes blank the digit.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  assign terminal       = up ? NINES : '0;
  assign at_term        = (count == terminal);
  assign stepped        = up ? bcd_inc(count) : bcd_dec(count);
  assign preset_clamped = clamp_bcd(preset);

  // NOTE: every output written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg_code(count[4*i +: 4]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of count, prescaler and state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prescaler <= '0;
      count     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count     <= preset_clamped;
        prescaler <= '0;
        state     <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            prescaler <= '0;
            if (!run_n) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end

          RUN: begin
            if (run_n) begin
              state <= PAUSE;
              busy  <= 1'b0;
            end else if (!wrap_en && at_term) begin
              // Started (or left) at the stop value: finish silently.
              state     <= DONE;
              busy      <= 1'b0;
              prescaler <= '0;
            end else if (prescaler == TICK_LAST) begin
              prescaler <= '0;
              count     <= stepped;
              if (at_term) begin
                done <= 1'b1;
              end else if (!wrap_en && (stepped == terminal)) begin
                done  <= 1'b1;
                state <= DONE;
                busy  <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end

          PAUSE: begin
            if (!run_n) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end

          DONE: begin
            prescaler <= '0;
          end

          default: begin
            state     <= IDLE;
            prescaler <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS=2, TICK_DIV=4; expected
// values are worked out by hand for each step.
module tb_bcd_countdown_timer;

  logic        clk;
  logic        reset;
  logic        run_n;
  logic        load;
  logic [7:0]  preset;
  logic        up;
  logic        wrap_en;
  logic [7:0]  count;
  logic [13:0] seg;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bcd_countdown_timer #(
    .DIGITS   (2),
    .TICK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run_n   (run_n),
    .load    (load),
    .preset  (preset),
    .up      (up),
    .wrap_en (wrap_en),
    .count   (count),
    .seg     (seg),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges; inputs and samples sit 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] p, input logic u, input logic w);
    preset  = p;
    up      = u;
    wrap_en = w;
    load    = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    run_n   = 1'b1;
    load    = 1'b0;
    preset  = 8'h00;
    up      = 1'b0;
    wrap_en = 1'b0;
    #2;
    check("reset_count", 32'(count), 32'h00);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_seg", 32'(seg), 32'({7'b1000000, 7'b1000000}));
    cyc(1);
    reset = 1'b1;

    // 12 -> 11 -> 10 -> 09 every four RUN cycles
    do_load(8'h12, 1'b0, 1'b0);
    check("load12_count", 32'(count), 32'h12);
    check("load12_busy", 32'(busy), 32'h0);
    run_n = 1'b0;
    cyc(1);
    check("run_busy", 32'(busy), 32'h1);
    cyc(3);
    check("pre_tick_count", 32'(count), 32'h12);
    cyc(1);
    check("step_11", 32'(count), 32'h11);
    cyc(4);
    check("step_10", 32'(count), 32'h10);
    cyc(4);
    check("borrow_09", 32'(count), 32'h09);
    check("seg_09", 32'(seg), 32'({7'b1000000, 7'b0010000}));
    check("no_done_09", 32'(done), 32'h0);

    // 02 down, stop: reaches 00, single done, DONE ignores run_n
    do_load(8'h02, 1'b0, 1'b0);
    check("load02_count", 32'(count), 32'h02);
    cyc(5);
    check("step_01", 32'(count), 32'h01);
    check("step_01_done", 32'(done), 32'h0);
    cyc(4);
    check("stop_00", 32'(count), 32'h00);
    check("stop_done", 32'(done), 32'h1);
    check("stop_busy", 32'(busy), 32'h0);
    cyc(1);
    check("stop_done_clear", 32'(done), 32'h0);
    run_n = 1'b1;
    cyc(1);
    run_n = 1'b0;
    cyc(6);
    check("done_hold_count", 32'(count), 32'h00);
    check("done_hold_busy", 32'(busy), 32'h0);
    check("done_hold_done", 32'(done), 32'h0);

    // 00 down, wrap: 99 with done, stays busy
    do_load(8'h00, 1'b0, 1'b1);
    cyc(4);
    check("wrap_pre_count", 32'(count), 32'h00);
    check("wrap_pre_busy", 32'(busy), 32'h1);
    cyc(1);
    check("wrap_99", 32'(count), 32'h99);
    check("wrap_done", 32'(done), 32'h1);
    check("wrap_busy", 32'(busy), 32'h1);
    cyc(1);
    check("wrap_done_clear", 32'(done), 32'h0);
    cyc(3);
    check("wrap_98", 32'(count), 32'h98);

    // 98 up, stop: 99 with done, then holds
    do_load(8'h98, 1'b1, 1'b0);
    cyc(5);
    check("up_99", 32'(count), 32'h99);
    check("up_99_done", 32'(done), 32'h1);
    check("up_99_busy", 32'(busy), 32'h0);
    cyc(5);
    check("up_99_hold", 32'(count), 32'h99);
    check("up_99_hold_done", 32'(done), 32'h0);

    // Carry 19 -> 20, then direction flip applies at next tick: 20 -> 19
    do_load(8'h19, 1'b1, 1'b0);
    cyc(5);
    check("carry_20", 32'(count), 32'h20);
    up = 1'b0;
    cyc(4);
    check("dir_flip_19", 32'(count), 32'h19);

    // Pause after two prescaler cycles keeps the partial count
    do_load(8'h50, 1'b0, 1'b0);
    cyc(3);
    run_n = 1'b1;
    cyc(1);
    check("pause_busy", 32'(busy), 32'h0);
    cyc(10);
    check("pause_count", 32'(count), 32'h50);
    run_n = 1'b0;
    cyc(1);
    check("resume_busy", 32'(busy), 32'h1);
    cyc(1);
    check("resume_hold", 32'(count), 32'h50);
    cyc(1);
    check("resume_49", 32'(count), 32'h49);

    // Load on a tick that would otherwise hit 00 and pulse done
    do_load(8'h01, 1'b0, 1'b0);
    cyc(4);
    check("pre_load_tick", 32'(count), 32'h01);
    do_load(8'h37, 1'b0, 1'b0);
    check("load_tick_count", 32'(count), 32'h37);
    check("load_tick_done", 32'(done), 32'h0);
    check("load_tick_busy", 32'(busy), 32'h0);
    check("load_tick_seg", 32'(seg), 32'({7'b0110000, 7'b1111000}));
    cyc(1);
    check("load_tick_done2", 32'(done), 32'h0);

    // Asynchronous reset mid-count, then a full prescale period counting up
    cyc(2);
    up    = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'h00);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_seg", 32'(seg), 32'({7'b1000000, 7'b1000000}));
    cyc(2);
    reset = 1'b1;
    cyc(4);
    check("post_rst_hold", 32'(count), 32'h00);
    check("post_rst_done", 32'(done), 32'h0);
    cyc(1);
    check("post_rst_01", 32'(count), 32'h01);

    // Starting at the stop value goes to DONE with no pulse
    do_load(8'h00, 1'b0, 1'b0);
    cyc(1);
    check("term_start_busy", 32'(busy), 32'h1);
    cyc(1);
    check("term_start_done", 32'(done), 32'h0);
    check("term_start_idle", 32'(busy), 32'h0);
    cyc(5);
    check("term_start_count", 32'(count), 32'h00);

    // Non-decimal preset digits saturate to 9
    run_n = 1'b1;
    do_load(8'hA5, 1'b0, 1'b0);
    check("clamp_hi", 32'(count), 32'h95);
    do_load(8'h3C, 1'b0, 1'b0);
    check("clamp_lo", 32'(count), 32'h39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
